mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Parametrised successor to the single-client memory controller: serves NUM_CH clients
//  (inst fetcher, load/store buffer, ...) over the one byte-serial RAM/IO port.
//  Each access is 1, 2 or 4 bytes. The block arbitrates between clients, serialises
//  bytes, stalls IO writes on UART back-pressure and aborts reads on flush.
//  Sits between the clients and the cpu top-level mem_* pins.
// PARAMETERS
//  NUM_CH      2      number of client channels, 1..4; channel 0 = inst fetcher
//  ARB_MODE    0      0 = round-robin, 1 = fixed priority (lower index wins)
//  FLUSH_MASK  2'b01  bit i=1: channel i's reads abort and its req is ignored while flush=1
// PORTS
//  clk             in   1          clock, all state on rising edge
//  rst             in   1          reset, asynchronous, active-low
//  rdy             in   1          0 = pause, hold all state
//  flush           in   1          abort in-flight reads of FLUSH_MASK channels
//  io_buffer_full  in   1          UART tx buffer full
//  mem_din         in   8          RAM/IO read byte, valid the cycle after mem_a
//  mem_dout        out  8          write byte
//  mem_a           out  32         byte address
//  mem_wr          out  1          1 = write this cycle
//  ch_req          in   NUM_CH     per-channel request, held until ch_done
//  ch_we           in   NUM_CH     1 = write
//  ch_len          in   2*NUM_CH   0 = 1B, 1 = 2B, 2 = 4B (3 illegal, treated as 4B)
//  ch_addr         in   32*NUM_CH  start address, stable while req=1
//  ch_wdata        in   32*NUM_CH  write data, little-endian, low bytes used
//  ch_done         out  NUM_CH     one-cycle completion pulse
//  rdata           out  32         read data, zero-extended, valid while ch_done
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, mem_a=0, mem_dout=0, mem_wr=0, ch_done=0, rdata=0,
//   RR pointer=0. Reset mid-write drops the remaining bytes; bytes already written stay.
//  All outputs registered. States: IDLE, RD, WR, WAIT_IO.
//  IDLE: at edge E0 pick the winner among ch_req, excluding FLUSH_MASK channels while
//   flush=1. RR: search starts one past the last winner. Latch addr/len/we/wdata.
//   Go to WR if we=1, else RD. Exception: WAIT_IO if we=1, addr[17:16]==2'b11 and
//   io_buffer_full=1.
//  RD, L bytes: cycle after edge E0+k drives mem_a=addr+k, mem_wr=0 (k<L).
//   Byte k is captured from mem_din at edge E0+k+2 into rdata[8k+7:8k].
//   ch_done and rdata are high/valid in the cycle after edge E0+L+1, then IDLE.
//  WR: cycle after edge E0+k drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
//   ch_done is high in the cycle after edge E0+L; mem_wr=0 in that cycle.
//   Any IO-space write byte whose cycle would start with io_buffer_full=1 goes to WAIT_IO.
//  WAIT_IO: mem_wr=0, byte index held. Resume WR at the first edge with io_buffer_full=0.
//  No req sampling on the edge that ends a ch_done cycle, so there is one bubble
//   cycle between grants. Clients drop req on the edge where they see ch_done=1.
//  flush=1 during RD for a FLUSH_MASK channel: next edge -> IDLE, no ch_done, mem_wr=0.
//   flush never aborts WR/WAIT_IO; a write always completes.
//   flush and a fresh grant in the same IDLE edge: the masked channel is excluded.
//  rdy=0: no state, pointer or output changes. mem_wr forced 0, mem_a held.
//   RAM keeps returning the same byte, so the capture on resume is still correct.
//   rdy=0 takes precedence over flush and io_buffer_full.
//  Arithmetic: addr+k is 32-bit wrapping; rdata bits above 8L are 0.
// TESTING
//  1 ch1 read len=2 @0x100 (RAM 0x34,0x12): mem_a=0x100,0x101; rdata=0x00001234, ch_done
//    exactly 3 edges after grant, ch_done[0]=0 throughout.
//  2 ch0 and ch1 both req continuously, ARB_MODE=0: grants alternate 0,1,0,1 with one
//    bubble between; ARB_MODE=1: ch0 always wins while its req is high.
//  3 ch1 write len=1 0x41 @0x30000 with io_buffer_full=1 for 5 cycles: mem_wr stays 0,
//    then exactly one mem_wr=1 at 0x30000 data 0x41, then ch_done.
//  4 ch0 read len=4, flush=1 one cycle after grant: FSM IDLE next edge, no ch_done;
//    a ch1 write in flight under flush still completes all 4 bytes.
//  5 rdy=0 for 3 cycles mid 4-byte read: mem_a held, mem_wr=0; rdata correct; done delayed 3.
//  6 rst=0 asserted between clock edges mid-write: mem_wr=0 immediately, no ch_done;
//    next req after release is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial RAM/IO port between NUM_CH clients.
// Each client access is 1, 2 or 4 bytes. The block arbitrates between clients
// (round-robin or fixed priority), serialises the bytes, stalls IO-space writes
// while the UART buffer is full, and aborts flushable reads.
//
// Ports
//   clk, rst (async, active-low), rdy (0 = pause), flush, io_buffer_full
//   mem_din/mem_dout/mem_a/mem_wr : byte-serial RAM/IO port (all registered)
//   ch_req/ch_we/ch_len/ch_addr/ch_wdata : packed per-channel request fields
//   ch_done : one-cycle completion pulse per channel
//   rdata   : zero-extended read data, valid while ch_done is high
module mem_arbiter #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ARB_MODE   = 0,
    parameter logic [3:0]  FLUSH_MASK = 4'b0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic                   io_buffer_full,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_a,
    output logic                   mem_wr,
    input  logic [NUM_CH-1:0]      ch_req,
    input  logic [NUM_CH-1:0]      ch_we,
    input  logic [2*NUM_CH-1:0]    ch_len,
    input  logic [32*NUM_CH-1:0]   ch_addr,
    input  logic [32*NUM_CH-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]      ch_done,
    output logic [31:0]            rdata
);

    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WAIT_IO} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_ch, w_ch_nxt;
    logic [CW-1:0]      r_ptr, w_ptr_nxt;
    logic [31:0]        r_addr, w_addr_nxt;
    logic [2:0]         r_len, w_len_nxt;
    logic [31:0]        r_wdata, w_wdata_nxt;
    logic [2:0]         r_cnt, w_cnt_nxt;
    logic [31:0]        r_mem_a, w_mem_a_nxt;
    logic [7:0]         r_mem_dout, w_mem_dout_nxt;
    logic               r_mem_wr, w_mem_wr_nxt;
    logic [NUM_CH-1:0]  r_done, w_done_nxt;
    logic [31:0]        r_rdata, w_rdata_nxt;

    // Arbitration results
    logic [NUM_CH-1:0]  w_req;
    logic               w_found;
    logic [CW-1:0]      w_win;
    int unsigned        w_idx;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [2:0]         w_sel_len;
    logic               w_sel_we;

    // Per-byte helpers
    logic [31:0]        w_cur_addr;
    logic               w_io;
    logic [7:0]         w_byte;
    logic [1:0]         w_cap;

    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign mem_wr   = r_mem_wr;
    assign ch_done  = r_done;
    assign rdata    = r_rdata;

    // Winner search; in round-robin mode r_ptr is the first channel examined.
    always_comb begin
        w_req       = ch_req & ~(flush ? FLUSH_MASK[NUM_CH-1:0] : '0);
        w_found     = 1'b0;
        w_win       = '0;
        w_idx       = 0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_len   = 3'd1;
        w_sel_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 0) begin
                w_idx = 32'(r_ptr) + i;
                if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            end else begin
                w_idx = i;
            end
            if (!w_found && w_req[w_idx]) begin
                w_found     = 1'b1;
                w_win       = CW'(w_idx);
                w_sel_addr  = ch_addr[32*w_idx +: 32];
                w_sel_wdata = ch_wdata[32*w_idx +: 32];
                w_sel_we    = ch_we[w_idx];
                unique case (ch_len[2*w_idx +: 2])
                    2'd0:    w_sel_len = 3'd1;
                    2'd1:    w_sel_len = 3'd2;
                    default: w_sel_len = 3'd4;
                endcase
            end
        end
    end

    // Next-state / next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_ch_nxt       = r_ch;
        w_ptr_nxt      = r_ptr;
        w_addr_nxt     = r_addr;
        w_len_nxt      = r_len;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_mem_a_nxt    = r_mem_a;
        w_mem_dout_nxt = r_mem_dout;
        w_mem_wr_nxt   = 1'b0;
        w_done_nxt     = '0;
        w_rdata_nxt    = r_rdata;
        w_cur_addr     = r_addr + 32'(r_cnt);
        w_io           = (w_cur_addr[17:16] == 2'b11);
        w_byte         = 8'(r_wdata >> {r_cnt, 3'b000});
        // Read byte k is captured when r_cnt == k+2 (two-cycle RAM round trip)
        w_cap          = r_cnt[1:0] - 2'd2;

        if (!rdy) begin
            w_done_nxt = r_done;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // r_done != 0 marks the completion cycle: no grant on its closing edge
                    if (r_done == '0 && w_found) begin
                        w_ch_nxt    = w_win;
                        w_ptr_nxt   = (w_win == CW'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
                        w_addr_nxt  = w_sel_addr;
                        w_len_nxt   = w_sel_len;
                        w_wdata_nxt = w_sel_wdata;
                        w_rdata_nxt = '0;
                        w_mem_a_nxt = w_sel_addr;
                        w_cnt_nxt   = 3'd1;
                        if (!w_sel_we) begin
                            w_state_nxt = S_RD;
                        end else if (w_sel_addr[17:16] == 2'b11 && io_buffer_full) begin
                            w_state_nxt = S_WAIT_IO;
                            w_cnt_nxt   = 3'd0;
                        end else begin
                            w_state_nxt    = S_WR;
                            w_mem_dout_nxt = w_sel_wdata[7:0];
                            w_mem_wr_nxt   = 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (flush && FLUSH_MASK[r_ch]) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        if (r_cnt < r_len) w_mem_a_nxt = w_cur_addr;
                        if (r_cnt >= 3'd2) w_rdata_nxt[{w_cap, 3'b000} +: 8] = mem_din;
                        if (r_cnt == r_len + 3'd1) begin
                            w_done_nxt[r_ch] = 1'b1;
                            w_state_nxt      = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end
                end
                S_WR: begin
                    if (r_cnt == r_len) begin
                        w_done_nxt[r_ch] = 1'b1;
                        w_state_nxt      = S_IDLE;
                    end else if (w_io && io_buffer_full) begin
                        w_state_nxt = S_WAIT_IO;
                    end else begin
                        w_mem_a_nxt    = w_cur_addr;
                        w_mem_dout_nxt = w_byte;
                        w_mem_wr_nxt   = 1'b1;
                        w_cnt_nxt      = r_cnt + 3'd1;
                    end
                end
                S_WAIT_IO: begin
                    if (!io_buffer_full) begin
                        w_mem_a_nxt    = w_cur_addr;
                        w_mem_dout_nxt = w_byte;
                        w_mem_wr_nxt   = 1'b1;
                        w_cnt_nxt      = r_cnt + 3'd1;
                        w_state_nxt    = S_WR;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_len      <= 3'd1;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_done     <= '0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ch       <= w_ch_nxt;
            r_ptr      <= w_ptr_nxt;
            r_addr     <= w_addr_nxt;
            r_len      <= w_len_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_done     <= w_done_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (dut) and a fixed-priority
// instance (fp) share all client inputs; a byte RAM model serves both.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, flush, iofull;
    logic [7:0]  mem_din, fp_din, mem_dout, fp_dout;
    logic [31:0] mem_a, fp_a, rdata, fp_rdata;
    logic        mem_wr, fp_wr;
    logic [1:0]  ch_req, ch_we, ch_done, fp_done;
    logic [3:0]  ch_len;
    logic [63:0] ch_addr, ch_wdata;

    logic [7:0]  ram [0:4095];
    logic        ram_init = 1'b0;

    typedef struct { int unsigned ch; logic [31:0] data; } rd_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
    rd_t rd_q[$];
    rd_t fp_q[$];
    wr_t wr_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    mem_arbiter #(.NUM_CH(2), .ARB_MODE(0), .FLUSH_MASK(4'b0001)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(iofull),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .ch_req(ch_req), .ch_we(ch_we), .ch_len(ch_len), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_done(ch_done), .rdata(rdata));

    mem_arbiter #(.NUM_CH(2), .ARB_MODE(1), .FLUSH_MASK(4'b0001)) fp (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(iofull),
        .mem_din(fp_din), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr),
        .ch_req(ch_req), .ch_we(ch_we), .ch_len(ch_len), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_done(fp_done), .rdata(fp_rdata));

    // RAM returns the addressed byte one cycle later and freezes while rdy=0
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 13 + 5);
            ram[12'h100] <= 8'h34;
            ram[12'h101] <= 8'h12;
            ram[12'h102] <= 8'h56;
            ram[12'h103] <= 8'h78;
            ram_init <= 1'b1;
        end else if (rdy) begin
            mem_din <= ram[mem_a[11:0]];
            fp_din  <= ram[fp_a[11:0]];
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        end
    end

    task automatic set_ch(input int c, input logic we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata);
        ch_we[c]            = we;
        ch_len[2*c +: 2]    = len;
        ch_addr[32*c +: 32] = addr;
        ch_wdata[32*c +: 32] = wdata;
    endtask

    task automatic do_reset;
        ch_req = '0; flush = 1'b0; iofull = 1'b0; rdy = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        ch_req = '0; ch_we = '0; ch_len = '0; ch_addr = '0; ch_wdata = '0;
        flush = 1'b0; iofull = 1'b0; rdy = 1'b1;
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_cmp++; if (mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (ch_done !== 2'b00) begin n_bad++; $display("FAIL reset_ch_done: got %b want 00", ch_done); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        do_reset();
    endtask

    task automatic test_read;
        int  done_at;
        rd_t e;
        done_at = -1;
        do_reset();
        set_ch(1, 1'b0, 2'd1, 32'h100, 32'h0);
        e.ch = 1; e.data = 32'h0000_1234; rd_q.push_back(e);
        ch_req[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c < 2) begin
                n_cmp++;
                if (mem_a !== 32'h100 + 32'(c) || mem_wr !== 1'b0) begin
                    n_bad++; $display("FAIL rd_addr c=%0d: got %h/%b want %h/0", c, mem_a, mem_wr, 32'h100 + 32'(c));
                end
            end
            n_cmp++; if (ch_done[0] !== 1'b0) begin n_bad++; $display("FAIL rd_done0 c=%0d: got 1 want 0", c); end
            if (ch_done[1] === 1'b1) begin
                done_at = c; ch_req[1] = 1'b0;
                n_cmp++;
                if (rd_q.size() == 0) begin n_bad++; $display("FAIL rd_extra_done: got done want none"); end
                else begin
                    e = rd_q.pop_front();
                    if (rdata !== e.data) begin n_bad++; $display("FAIL rd_data: got %h want %h", rdata, e.data); end
                end
            end
        end
        n_cmp++; if (done_at != 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", done_at); end
    endtask

    task automatic test_arb;
        rd_t e;
        do_reset();
        set_ch(0, 1'b0, 2'd0, 32'h200, 32'h0);
        set_ch(1, 1'b0, 2'd0, 32'h300, 32'h0);
        for (int i = 0; i < 6; i++) begin
            e.ch = i % 2; e.data = {24'h0, (i % 2 == 0) ? ram[12'h200] : ram[12'h300]};
            rd_q.push_back(e);
            e.ch = 0; e.data = {24'h0, ram[12'h200]};
            fp_q.push_back(e);
        end
        ch_req = 2'b11;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (ch_done !== 2'b00) begin
                n_cmp++;
                if (rd_q.size() == 0) begin n_bad++; $display("FAIL rr_extra_done: got %b want none", ch_done); end
                else begin
                    e = rd_q.pop_front();
                    if (ch_done !== 2'(1 << e.ch) || rdata !== e.data) begin
                        n_bad++; $display("FAIL rr_grant: got done=%b data=%h want ch%0d data=%h", ch_done, rdata, e.ch, e.data);
                    end
                end
            end
            if (fp_done !== 2'b00) begin
                n_cmp++;
                if (fp_q.size() == 0) begin n_bad++; $display("FAIL fp_extra_done: got %b want none", fp_done); end
                else begin
                    e = fp_q.pop_front();
                    if (fp_done !== 2'(1 << e.ch) || fp_rdata !== e.data) begin
                        n_bad++; $display("FAIL fp_grant: got done=%b data=%h want ch%0d data=%h", fp_done, fp_rdata, e.ch, e.data);
                    end
                end
            end
        end
        ch_req = 2'b00;
        n_cmp++; if (rd_q.size() != 0) begin n_bad++; $display("FAIL rr_missing: got %0d left want 0", rd_q.size()); end
        n_cmp++; if (fp_q.size() != 0) begin n_bad++; $display("FAIL fp_missing: got %0d left want 0", fp_q.size()); end
        rd_q.delete(); fp_q.delete();
    endtask

    task automatic test_io_stall;
        int  done_at, n_wr;
        wr_t w;
        done_at = -1; n_wr = 0;
        do_reset();
        iofull = 1'b1;
        set_ch(1, 1'b1, 2'd0, 32'h0003_0000, 32'h41);
        w.addr = 32'h0003_0000; w.data = 8'h41; wr_q.push_back(w);
        ch_req[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c < 5) begin
                n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL io_stall_wr c=%0d: got %b want 0", c, mem_wr); end
            end
            if (mem_wr === 1'b1) begin
                n_wr++; n_cmp++;
                if (wr_q.size() == 0) begin n_bad++; $display("FAIL io_extra_wr: got %h@%h want none", mem_dout, mem_a); end
                else begin
                    w = wr_q.pop_front();
                    if (mem_a !== w.addr || mem_dout !== w.data) begin
                        n_bad++; $display("FAIL io_wr: got %h@%h want %h@%h", mem_dout, mem_a, w.data, w.addr);
                    end
                end
            end
            if (ch_done[1] === 1'b1) begin done_at = c; ch_req[1] = 1'b0; end
            if (c == 4) iofull = 1'b0;
        end
        n_cmp++; if (n_wr != 1) begin n_bad++; $display("FAIL io_wr_count: got %0d want 1", n_wr); end
        n_cmp++; if (done_at != 6) begin n_bad++; $display("FAIL io_done: got %0d want 6", done_at); end
        wr_q.delete();
    endtask

    task automatic test_flush;
        int  done_at;
        wr_t w;
        done_at = -1;
        // flushed read: aborts without ch_done
        do_reset();
        set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
        ch_req[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (ch_done !== 2'b00) begin n_bad++; $display("FAIL flush_done c=%0d: got %b want 00", c, ch_done); end
            if (c == 1) begin
                n_cmp++; if (mem_a !== 32'h100) begin n_bad++; $display("FAIL flush_abort: got %h want 00000100", mem_a); end
                flush = 1'b0; ch_req[0] = 1'b0;
            end
            if (c == 0) flush = 1'b1;
        end
        // write under flush completes; masked ch0 excluded at the same grant edge
        do_reset();
        flush = 1'b1;
        set_ch(0, 1'b0, 2'd0, 32'h200, 32'h0);
        set_ch(1, 1'b1, 2'd2, 32'h400, 32'hDDCC_BBAA);
        for (int i = 0; i < 4; i++) begin
            w.addr = 32'h400 + 32'(i); w.data = 8'(32'hDDCC_BBAA >> (8 * i)); wr_q.push_back(w);
        end
        ch_req = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_wr === 1'b1) begin
                n_cmp++;
                if (wr_q.size() == 0) begin n_bad++; $display("FAIL fl_extra_wr: got %h@%h want none", mem_dout, mem_a); end
                else begin
                    w = wr_q.pop_front();
                    if (mem_a !== w.addr || mem_dout !== w.data) begin
                        n_bad++; $display("FAIL fl_wr: got %h@%h want %h@%h", mem_dout, mem_a, w.data, w.addr);
                    end
                end
            end
            n_cmp++; if (ch_done[0] !== 1'b0) begin n_bad++; $display("FAIL fl_masked_done c=%0d: got 1 want 0", c); end
            if (ch_done[1] === 1'b1) begin done_at = c; ch_req[1] = 1'b0; end
        end
        flush = 1'b0; ch_req = 2'b00;
        n_cmp++; if (done_at != 4) begin n_bad++; $display("FAIL fl_wr_done: got %0d want 4", done_at); end
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL fl_wr_missing: got %0d left want 0", wr_q.size()); end
        wr_q.delete();
    endtask

    task automatic test_pause;
        int  done_at;
        rd_t e;
        done_at = -1;
        do_reset();
        set_ch(1, 1'b0, 2'd2, 32'h100, 32'h0);
        e.ch = 1; e.data = 32'h7856_1234; rd_q.push_back(e);
        ch_req[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if (mem_a !== 32'h101 || mem_wr !== 1'b0) begin
                    n_bad++; $display("FAIL pause_hold c=%0d: got %h/%b want 00000101/0", c, mem_a, mem_wr);
                end
            end
            if (c == 5) begin
                n_cmp++; if (mem_a !== 32'h102) begin n_bad++; $display("FAIL pause_resume: got %h want 00000102", mem_a); end
            end
            if (ch_done[1] === 1'b1) begin
                done_at = c; ch_req[1] = 1'b0;
                n_cmp++;
                if (rd_q.size() == 0) begin n_bad++; $display("FAIL pause_extra_done: got done want none"); end
                else begin
                    e = rd_q.pop_front();
                    if (rdata !== e.data) begin n_bad++; $display("FAIL pause_data: got %h want %h", rdata, e.data); end
                end
            end
            if (c == 1) rdy = 1'b0;
            if (c == 4) rdy = 1'b1;
        end
        n_cmp++; if (done_at != 8) begin n_bad++; $display("FAIL pause_latency: got %0d want 8", done_at); end
        rd_q.delete();
    endtask

    task automatic test_back_to_back_reset;
        int          done_at;
        logic [7:0]  old501;
        wr_t         w;
        rd_t         e;
        done_at = -1;
        do_reset();
        old501 = ram[12'h501];
        set_ch(0, 1'b1, 2'd2, 32'h500, 32'h4433_2211);
        for (int i = 0; i < 2; i++) begin
            w.addr = 32'h500 + 32'(i); w.data = 8'(32'h4433_2211 >> (8 * i)); wr_q.push_back(w);
        end
        ch_req[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mem_wr !== 1'b1 || wr_q.size() == 0) begin
                n_bad++; $display("FAIL rst_pre_wr c=%0d: got wr=%b want 1", c, mem_wr);
            end else begin
                w = wr_q.pop_front();
                if (mem_a !== w.addr || mem_dout !== w.data) begin
                    n_bad++; $display("FAIL rst_pre_wr c=%0d: got %h@%h want %h@%h", c, mem_dout, mem_a, w.data, w.addr);
                end
            end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_async_wr: got %b want 0", mem_wr); end
        n_cmp++; if (ch_done !== 2'b00) begin n_bad++; $display("FAIL rst_async_done: got %b want 00", ch_done); end
        ch_req = 2'b00;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ram[12'h500] !== 8'h11) begin n_bad++; $display("FAIL rst_kept_byte: got %h want 11", ram[12'h500]); end
        n_cmp++; if (ram[12'h501] !== old501) begin n_bad++; $display("FAIL rst_dropped_byte: got %h want %h", ram[12'h501], old501); end
        set_ch(0, 1'b0, 2'd0, 32'h500, 32'h0);
        e.ch = 0; e.data = 32'h11; rd_q.push_back(e);
        ch_req[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ch_done !== 2'b00) begin
                done_at = c; ch_req[0] = 1'b0;
                n_cmp++;
                if (rd_q.size() == 0) begin n_bad++; $display("FAIL rst_extra_done: got %b want none", ch_done); end
                else begin
                    e = rd_q.pop_front();
                    if (ch_done !== 2'b01 || rdata !== e.data) begin
                        n_bad++; $display("FAIL rst_next_rd: got %b/%h want 01/%h", ch_done, rdata, e.data);
                    end
                end
            end
        end
        n_cmp++; if (done_at != 2) begin n_bad++; $display("FAIL rst_next_latency: got %0d want 2", done_at); end
        rd_q.delete();
    endtask

    initial begin
        test_reset();
        test_read();
        test_arb();
        test_io_stall();
        test_flush();
        test_pause();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
